darkkey: RTL and testbench

- Scans a 4x4 hex matrix keypad, synchronizes and debounces it, and delivers one 4-bit key code per press through a ready/acknowledge holding register.
- Also shifts each accepted digit into a 32-bit entry register.
- Input-side counterpart to the 8-digit hex display driver: a value typed on the keypad arrives in DATA in the same nibble order the display uses, so DATA can be looped straight to the display.
- Sits on the SoC I/O bus beside the display controller.

---
 rtl/darkkey_pkg.sv | 26 ++
 rtl/darkkey_sync.sv | 23 ++
 rtl/darkkey.sv | 178 +++++++++++++++++
 tb/tb_darkkey.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkkey_pkg.sv
// Shared types and constants for the darkkey keypad scanner.
// Holds the FSM encoding, the column reset pattern and the key-code map.
package darkkey_pkg;

   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_HELD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;

   // Rows 0..2 of columns 0..2 form the 1..9 block; column 3 is A..D and row 3 is 0,F,E.
   function automatic logic [3:0] keymap(input logic [1:0] col, input logic [1:0] row);
      logic [3:0] code;
      if (col == 2'd3)
         code = 4'hA + {2'b00, row};
      else if (row == 2'd3)
         code = (col == 2'd0) ? 4'h0 : (col == 2'd1) ? 4'hF : 4'hE;
      else
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      return code;
   endfunction

endpackage

// File: rtl/darkkey_sync.sv
// Generic 2-flop synchronizer; flops come out of reset at 1 to match idle pulled-up inputs.
module darkkey_sync #(
   parameter int W = 1
) (
   input  logic         CLK,
   input  logic         RES,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/darkkey.sv
// 4x4 hex keypad scanner with debounce, ready/ack key holding register and 8-digit entry shift register.
//
// state   | meaning
// SCAN    | rotating columns, waiting for any row low
// CONFIRM | column frozen, counting identical samples of a candidate key
// HELD    | key accepted, waiting for all rows high
// RELEASE | column frozen, counting release samples before resuming scan
module darkkey
   import darkkey_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int DEB_SCANS = 4
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic [3:0]  ROW,
   output logic [3:0]  COL,
   output logic [3:0]  KEY_CODE,
   output logic        KEY_RDY,
   output logic        KEY_OVF,
   input  logic        KEY_ACK,
   input  logic        CLR,
   output logic [31:0] DATA
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_LAST = 4'(DEB_SCANS);

   logic [DIV_W-1:0] div_cnt;
   logic             sample;
   logic [3:0]       row_sync;
   logic             any_low;
   logic [1:0]       row_idx;
   logic [1:0]       col_idx;
   logic [3:0]       code_now;
   logic [3:0]       code_q;
   logic             same_code;
   logic [3:0]       cnt;
   logic [3:0]       cnt_inc;
   state_t           state;
   state_t           state_nx;
   logic             advance;
   logic             accept;
   logic             cnt_load;
   logic             cnt_bump;
   logic             code_load;

   darkkey_sync #(.W(4)) u_row_sync (
      .CLK (CLK),
      .RES (RES),
      .d   (ROW),
      .q   (row_sync)
   );

   assign sample = (div_cnt == DIV_LAST);

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) div_cnt <= '0;
      else      div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
   end

   assign any_low = (row_sync != 4'hF);

   always_comb begin
      row_idx = 2'd3;
      if      (!row_sync[0]) row_idx = 2'd0;
      else if (!row_sync[1]) row_idx = 2'd1;
      else if (!row_sync[2]) row_idx = 2'd2;
   end

   always_comb begin
      case (COL)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase
   end

   assign code_now  = keymap(col_idx, row_idx);
   assign same_code = (code_now == code_q);
   assign cnt_inc   = cnt + 4'd1;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) state <= ST_SCAN;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (sample) begin
         case (state)
            ST_SCAN:
               if (any_low) state_nx = ST_CONFIRM;
            ST_CONFIRM:
               if (!(any_low && same_code)) state_nx = ST_SCAN;
               else if (cnt_inc == DEB_LAST) state_nx = ST_HELD;
            ST_HELD:
               if (!any_low) state_nx = ST_RELEASE;
            ST_RELEASE:
               if (any_low) state_nx = ST_HELD;
               else if (cnt_inc == DEB_LAST) state_nx = ST_SCAN;
            default:
               state_nx = ST_SCAN;
         endcase
      end
   end

   always_comb begin
      advance   = 1'b0;
      accept    = 1'b0;
      cnt_load  = 1'b0;
      cnt_bump  = 1'b0;
      code_load = 1'b0;
      if (sample) begin
         case (state)
            ST_SCAN:
               if (any_low) begin
                  code_load = 1'b1;
                  cnt_load  = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            ST_CONFIRM:
               if (any_low && same_code) begin
                  cnt_bump = 1'b1;
                  accept   = (cnt_inc == DEB_LAST);
               end else begin
                  advance = 1'b1;
               end
            ST_HELD:
               cnt_load = !any_low;
            ST_RELEASE:
               if (!any_low) begin
                  cnt_bump = 1'b1;
                  advance  = (cnt_inc == DEB_LAST);
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         COL    <= COL_RESET;
         cnt    <= 4'd0;
         code_q <= 4'd0;
      end else begin
         if (advance)        COL    <= {COL[2:0], COL[3]};
         if (cnt_load)       cnt    <= 4'd1;
         else if (cnt_bump)  cnt    <= cnt_inc;
         if (code_load)      code_q <= code_now;
      end
   end

   // An accept beats a same-cycle ACK; the ACK only suppresses the overflow flag.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         KEY_CODE <= 4'd0;
         KEY_RDY  <= 1'b0;
         KEY_OVF  <= 1'b0;
         DATA     <= 32'd0;
      end else begin
         if (accept) begin
            KEY_CODE <= code_q;
            KEY_RDY  <= 1'b1;
            KEY_OVF  <= KEY_ACK ? 1'b0 : (KEY_OVF | KEY_RDY);
         end else if (KEY_ACK) begin
            KEY_RDY  <= 1'b0;
            KEY_OVF  <= 1'b0;
         end
         if (accept)   DATA <= {(CLR ? 28'd0 : DATA[27:0]), code_q};
         else if (CLR) DATA <= 32'd0;
      end
   end

endmodule

// File: tb/tb_darkkey.sv
// Self-checking bench for darkkey: a keypad model drives ROW from COL, a reference model tracks outputs.
module tb_darkkey;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam logic [3:0] KMAP [4][4] = '{
      '{4'h1, 4'h4, 4'h7, 4'h0},
      '{4'h2, 4'h5, 4'h8, 4'hF},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hB, 4'hC, 4'hD}};

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [3:0]  KEY_CODE;
   logic        KEY_RDY;
   logic        KEY_OVF;
   logic        KEY_ACK = 1'b0;
   logic        CLR = 1'b0;
   logic [31:0] DATA;

   logic [15:0] keys = 16'h0;
   int          n_run = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   logic        rdy_prev = 1'b0;

   logic [3:0]  m_code;
   logic        m_rdy;
   logic        m_ovf;
   logic [31:0] m_data;

   always #5 CLK = ~CLK;

   darkkey #(.SCAN_DIV(SD), .DEB_SCANS(DB)) dut (
      .CLK      (CLK),
      .RES      (RES),
      .ROW      (ROW),
      .COL      (COL),
      .KEY_CODE (KEY_CODE),
      .KEY_RDY  (KEY_RDY),
      .KEY_OVF  (KEY_OVF),
      .KEY_ACK  (KEY_ACK),
      .CLR      (CLR),
      .DATA     (DATA)
   );

   // Physical keypad: a closed key pulls its row low while its column is driven low.
   always_comb begin
      ROW = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!COL[c] && keys[c*4+r]) ROW[r] = 1'b0;
   end

   always @(negedge CLK) begin
      if (KEY_RDY && !rdy_prev) acc_cnt <= acc_cnt + 1;
      rdy_prev <= KEY_RDY;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] col_drive(int c);
      logic [3:0] t;
      t    = 4'hF;
      t[c] = 1'b0;
      return t;
   endfunction

   task automatic m_reset();
      m_code = 4'h0; m_rdy = 1'b0; m_ovf = 1'b0; m_data = 32'h0;
   endtask

   task automatic m_accept(input logic [3:0] code, input logic ack, input logic clr);
      m_ovf  = ack ? 1'b0 : (m_ovf | m_rdy);
      m_rdy  = 1'b1;
      m_code = code;
      m_data = clr ? {28'h0, code} : {m_data[27:0], code};
   endtask

   task automatic pulse_ack();
      @(negedge CLK) KEY_ACK = 1'b1;
      @(negedge CLK) KEY_ACK = 1'b0;
      m_rdy = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic press(input int c, input int r, input int hold, input int gap);
      keys[c*4+r] = 1'b1;
      repeat (hold) @(negedge CLK);
      keys = 16'h0;
      repeat (gap) @(negedge CLK);
   endtask

   task automatic wait_col(input int c, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge CLK);
         if (COL === col_drive(c)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RES = 1'b0;
      keys = 16'h0;
      m_reset();
      repeat (3) @(negedge CLK);
      n_run++;
      if (COL !== 4'b1110 || KEY_RDY !== 1'b0 || KEY_OVF !== 1'b0 || DATA !== 32'h0 || KEY_CODE !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_values: got COL=%b RDY=%b OVF=%b CODE=%h DATA=%h", COL, KEY_RDY, KEY_OVF, KEY_CODE, DATA);
      end
      RES = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge CLK);
         n_run++;
         if (COL !== col_drive((n / SD) % 4)) begin
            n_fail++;
            $display("FAIL reset_rotation: edge %0d got COL=%b want %b", n, COL, col_drive((n / SD) % 4));
         end
      end
   endtask

   task automatic test_clean_press();
      int a0;
      a0 = acc_cnt;
      press(1, 2, 40, 60);
      m_accept(4'h8, 1'b0, 1'b0);
      n_run++;
      if (acc_cnt !== a0 + 1) begin
         n_fail++;
         $display("FAIL clean_count: got %0d accepts want 1", acc_cnt - a0);
      end
      n_run++;
      if (KEY_CODE !== 4'h8 || KEY_RDY !== 1'b1 || DATA !== 32'h0000_0008 || KEY_OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_outputs: got CODE=%h RDY=%b OVF=%b DATA=%h want 8 1 0 00000008", KEY_CODE, KEY_RDY, KEY_OVF, DATA);
      end
      pulse_ack();
      n_run++;
      if (KEY_RDY !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_ack: got RDY=%b want 0", KEY_RDY);
      end
   endtask

   task automatic test_bounce();
      int a0;
      a0 = acc_cnt;
      // Closed spans never cover three consecutive samples; open spans always cover one.
      for (int b = 0; b < 8; b++) begin
         keys[0] = 1'b1;
         repeat ($urandom_range(1, 8)) @(negedge CLK);
         keys[0] = 1'b0;
         repeat ($urandom_range(4, 6)) @(negedge CLK);
      end
      n_run++;
      if (acc_cnt !== a0 || KEY_RDY !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_quiet: got %0d accepts RDY=%b want 0 0", acc_cnt - a0, KEY_RDY);
      end
      press(0, 0, 40, 60);
      m_accept(4'h1, 1'b0, 1'b0);
      n_run++;
      if (acc_cnt !== a0 + 1 || KEY_CODE !== 4'h1 || DATA !== m_data) begin
         n_fail++;
         $display("FAIL bounce_accept: got n=%0d CODE=%h DATA=%h want 1 1 %h", acc_cnt - a0, KEY_CODE, DATA, m_data);
      end
      pulse_ack();
   endtask

   task automatic test_entry();
      for (int k = 1; k <= 9; k++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (KMAP[c][r] == 4'(k)) press(c, r, 40, 40);
         m_accept(4'(k), 1'b0, 1'b0);
      end
      n_run++;
      if (DATA !== 32'h2345_6789 || DATA !== m_data) begin
         n_fail++;
         $display("FAIL entry_data: got %h want 23456789", DATA);
      end
      n_run++;
      if (KEY_OVF !== 1'b1 || KEY_CODE !== 4'h9 || KEY_RDY !== 1'b1) begin
         n_fail++;
         $display("FAIL entry_flags: got OVF=%b CODE=%h RDY=%b want 1 9 1", KEY_OVF, KEY_CODE, KEY_RDY);
      end
      pulse_ack();
      n_run++;
      if (KEY_RDY !== 1'b0 || KEY_OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL entry_ack: got RDY=%b OVF=%b want 0 0", KEY_RDY, KEY_OVF);
      end
   endtask

   // Presses a key timed from the column reaching it, so the accept edge is known exactly.
   task automatic press_aligned(input int c, input int r, input logic do_ack, input logic do_clr);
      bit ok;
      wait_col((c + 1) % 4, ok);
      keys[c*4+r] = 1'b1;
      if (ok) wait_col(c, ok);
      n_run++;
      if (!ok) begin
         n_fail++;
         $display("FAIL aligned_col: COL=%b never reached column %0d", COL, c);
         keys = 16'h0;
         return;
      end
      repeat (SD * DB - 1) @(posedge CLK);
      @(negedge CLK);
      n_run++;
      if (KEY_CODE !== m_code || DATA !== m_data || KEY_RDY !== m_rdy) begin
         n_fail++;
         $display("FAIL aligned_early: got CODE=%h DATA=%h RDY=%b want %h %h %b", KEY_CODE, DATA, KEY_RDY, m_code, m_data, m_rdy);
      end
      KEY_ACK = do_ack;
      CLR     = do_clr;
      @(negedge CLK);
      KEY_ACK = 1'b0;
      CLR     = 1'b0;
      m_accept(KMAP[c][r], do_ack, do_clr);
      n_run++;
      if (KEY_CODE !== m_code || DATA !== m_data || KEY_RDY !== m_rdy || KEY_OVF !== m_ovf) begin
         n_fail++;
         $display("FAIL aligned_accept: got CODE=%h DATA=%h RDY=%b OVF=%b want %h %h %b %b",
                  KEY_CODE, DATA, KEY_RDY, KEY_OVF, m_code, m_data, m_rdy, m_ovf);
      end
      repeat (30) @(negedge CLK);
      keys = 16'h0;
      repeat (40) @(negedge CLK);
   endtask

   task automatic test_collisions();
      press(0, 1, 40, 40);
      m_accept(4'h4, 1'b0, 1'b0);
      press_aligned(3, 0, 1'b1, 1'b0);
      n_run++;
      if (KEY_RDY !== 1'b1 || KEY_OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_ack: got RDY=%b OVF=%b want 1 0", KEY_RDY, KEY_OVF);
      end
      pulse_ack();
      press_aligned(3, 3, 1'b0, 1'b1);
      n_run++;
      if (DATA !== 32'h0000_000D) begin
         n_fail++;
         $display("FAIL collide_clr: got DATA=%h want 0000000d", DATA);
      end
      pulse_ack();
   endtask

   task automatic test_random();
      int c;
      int r;
      for (int i = 0; i < 12; i++) begin
         c = $urandom_range(0, 3);
         r = $urandom_range(0, 3);
         press(c, r, $urandom_range(36, 50), $urandom_range(30, 45));
         m_accept(KMAP[c][r], 1'b0, 1'b0);
         n_run++;
         if (KEY_CODE !== m_code || DATA !== m_data || KEY_RDY !== m_rdy || KEY_OVF !== m_ovf) begin
            n_fail++;
            $display("FAIL random_%0d: got CODE=%h DATA=%h RDY=%b OVF=%b want %h %h %b %b",
                     i, KEY_CODE, DATA, KEY_RDY, KEY_OVF, m_code, m_data, m_rdy, m_ovf);
         end
         if ($urandom_range(0, 1) == 1) pulse_ack();
      end
      pulse_ack();
   endtask

   task automatic test_two_keys_reset();
      bit got;
      keys[2*4+1] = 1'b1;
      keys[2*4+3] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge CLK);
         got = KEY_RDY;
      end
      m_accept(4'h6, 1'b0, 1'b0);
      n_run++;
      if (!got || KEY_CODE !== 4'h6 || DATA !== m_data) begin
         n_fail++;
         $display("FAIL two_keys: got RDY=%b CODE=%h DATA=%h want 1 6 %h", got, KEY_CODE, DATA, m_data);
      end
      repeat (10) @(negedge CLK);
      RES = 1'b0;
      m_reset();
      #2;
      n_run++;
      if (COL !== 4'b1110 || KEY_CODE !== 4'h0 || KEY_RDY !== 1'b0 || KEY_OVF !== 1'b0 || DATA !== 32'h0) begin
         n_fail++;
         $display("FAIL held_reset: got COL=%b CODE=%h RDY=%b OVF=%b DATA=%h want reset values", COL, KEY_CODE, KEY_RDY, KEY_OVF, DATA);
      end
      repeat (3) @(negedge CLK);
      RES = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge CLK);
         got = KEY_RDY;
      end
      m_accept(4'h6, 1'b0, 1'b0);
      n_run++;
      if (!got || KEY_CODE !== 4'h6 || DATA !== 32'h0000_0006 || KEY_OVF !== 1'b0) begin
         n_fail++;
         $display("FAIL reaccept: got RDY=%b CODE=%h DATA=%h OVF=%b want 1 6 00000006 0", got, KEY_CODE, DATA, KEY_OVF);
      end
      keys = 16'h0;
      repeat (40) @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_entry();
      test_collisions();
      test_random();
      test_two_keys_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
